// File: rtl/pac_move_sched_pkg.sv
// Shared state/direction codes and default tuning constants for the Pac-Man move scheduler.
package pac_pkg;

  localparam int TICK_DIV_DEF    = 5;
  localparam int READY_TICKS_DEF = 20;
  localparam int DEATH_TICKS_DEF = 15;
  localparam int LIVES_DEF       = 3;
  localparam int BUF_TICKS_DEF   = 8;
  localparam int NUM_PELLETS_DEF = 8;

  // Width shared by the tick divider, phase counter and request age counter.
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READY  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_DYING  = 3'd3,
    ST_WON    = 3'd4,
    ST_OVER   = 3'd5,
    ST_PAUSED = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

  // btn is {down, left, right, up}; up wins, down only when it is alone.
  function automatic dir_t prio_dir(input logic [3:0] btn);
    dir_t d;
    if (btn[0])      d = DIR_UP;
    else if (btn[1]) d = DIR_RIGHT;
    else if (btn[2]) d = DIR_LEFT;
    else             d = DIR_DOWN;
    return d;
  endfunction

endpackage

// File: rtl/pac_move_sched_if.sv
// Button/sprite-side bundle of the move scheduler; the pause input exists only with PAC_PAUSE_EN.
interface pac_move_sched_if #(
  parameter int NUM_PELLETS = pac_pkg::NUM_PELLETS_DEF
);
  logic                   tick;
  logic                   start;
  logic                   btn_up;
  logic                   btn_right;
  logic                   btn_left;
  logic                   btn_down;
  logic                   wall_up;
  logic                   wall_right;
  logic                   wall_left;
  logic                   wall_down;
  logic [NUM_PELLETS-1:0] pellet_eaten;
  logic                   ghost_hit;
`ifdef PAC_PAUSE_EN
  logic                   pause;
`endif
  logic                   move_valid;
  logic [1:0]             move_dir;
  logic [1:0]             cur_dir;
  logic [2:0]             state;
  logic [1:0]             lives;
  logic                   sprite_rst;

  modport slave (
`ifdef PAC_PAUSE_EN
    input  pause,
`endif
    input  tick, start, btn_up, btn_right, btn_left, btn_down,
    input  wall_up, wall_right, wall_left, wall_down, pellet_eaten, ghost_hit,
    output move_valid, move_dir, cur_dir, state, lives, sprite_rst
  );

  modport master (
`ifdef PAC_PAUSE_EN
    output pause,
`endif
    output tick, start, btn_up, btn_right, btn_left, btn_down,
    output wall_up, wall_right, wall_left, wall_down, pellet_eaten, ghost_hit,
    input  move_valid, move_dir, cur_dir, state, lives, sprite_rst
  );
endinterface

// File: rtl/pac_move_sched_dir_arb.sv
// Direction arbiter: picks one button by priority and keeps it buffered for BUF_TICKS ticks.
module pac_dir_arb
  import pac_pkg::*;
#(
  parameter int BUF_TICKS = BUF_TICKS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic       tick,
  input  logic       clear,
  input  logic       consume,
  output logic       req_valid,
  output dir_t       req_dir
);

  localparam logic [CNT_W-1:0] BUF_LOAD = CNT_W'(BUF_TICKS);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic             valid_reg, valid_next;
  dir_t             dir_reg, dir_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // A fresh press beats both consumption and ageing in the same cycle.
  always_comb begin
    valid_next = valid_reg;
    dir_next   = dir_reg;
    cnt_next   = cnt_reg;
    if (clear) begin
      valid_next = 1'b0;
      cnt_next   = '0;
    end else if (|btn) begin
      valid_next = 1'b1;
      dir_next   = prio_dir(btn);
      cnt_next   = BUF_LOAD;
    end else if (consume) begin
      valid_next = 1'b0;
      cnt_next   = '0;
    end else if (tick && valid_reg) begin
      cnt_next = cnt_reg - ONE;
      if (cnt_reg <= ONE) valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= 1'b0;
      dir_reg   <= DIR_UP;
      cnt_reg   <= '0;
    end else begin
      valid_reg <= valid_next;
      dir_reg   <= dir_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign req_valid = valid_reg;
  assign req_dir   = dir_reg;

endmodule

// File: rtl/pac_move_sched.sv
// Game FSM, lives, step divider and move-slot logic for the Pac-Man sprite datapath.
// Optional pause support is compiled in with PAC_PAUSE_EN.
module pac_move_sched
  import pac_pkg::*;
#(
  parameter int TICK_DIV    = TICK_DIV_DEF,
  parameter int READY_TICKS = READY_TICKS_DEF,
  parameter int DEATH_TICKS = DEATH_TICKS_DEF,
  parameter int LIVES       = LIVES_DEF,
  parameter int BUF_TICKS   = BUF_TICKS_DEF,
  parameter int NUM_PELLETS = NUM_PELLETS_DEF
) (
  input logic              clk,
  input logic              rst,
  pac_move_sched_if.slave  bus
);

  localparam logic [CNT_W-1:0]       DIV_LAST   = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]       READY_LAST = CNT_W'(READY_TICKS - 1);
  localparam logic [CNT_W-1:0]       DEATH_LAST = CNT_W'(DEATH_TICKS - 1);
  localparam logic [CNT_W-1:0]       ONE        = CNT_W'(1);
  localparam logic [1:0]             LIVES_LOAD = 2'(LIVES);
  localparam logic [NUM_PELLETS-1:0] ALL_EATEN  = '1;

  state_t           state_reg, state_next;
  logic [1:0]       lives_reg, lives_next;
  dir_t             cur_dir_reg, cur_dir_next;
  logic             moving_reg, moving_next;
  logic [CNT_W-1:0] div_reg, div_next;
  logic [CNT_W-1:0] phase_reg, phase_next;
  logic             move_valid_reg, move_valid_next;
  dir_t             move_dir_reg, move_dir_next;
  logic             sprite_rst_reg, sprite_rst_next;

  logic [3:0] btn_vec;
  logic [3:0] wall_vec;
  logic       in_play;
  logic       buf_keep;
  logic       take_req;
  logic       req_valid;
  dir_t       req_dir;

  assign btn_vec  = {bus.btn_down, bus.btn_left, bus.btn_right, bus.btn_up};
  assign wall_vec = {bus.wall_down, bus.wall_left, bus.wall_right, bus.wall_up};
  assign in_play  = (state_reg == ST_PLAY);

`ifdef PAC_PAUSE_EN
  logic pause_d_reg;
  logic pause_rise;
  assign pause_rise = bus.pause & ~pause_d_reg;
  assign buf_keep   = in_play || (state_reg == ST_PAUSED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pause_d_reg <= 1'b0;
    else      pause_d_reg <= bus.pause;
  end
`else
  assign buf_keep = in_play;
`endif

  // Outside PLAY the arbiter sees no buttons and no ticks, so a paused buffer simply holds.
  pac_dir_arb #(
    .BUF_TICKS (BUF_TICKS)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .btn       (in_play ? btn_vec : 4'b0000),
    .tick      (bus.tick & in_play),
    .clear     (~buf_keep),
    .consume   (take_req),
    .req_valid (req_valid),
    .req_dir   (req_dir)
  );

  always_comb begin
    state_next      = state_reg;
    lives_next      = lives_reg;
    cur_dir_next    = cur_dir_reg;
    moving_next     = moving_reg;
    div_next        = div_reg;
    phase_next      = phase_reg;
    move_valid_next = 1'b0;
    move_dir_next   = move_dir_reg;
    sprite_rst_next = 1'b0;
    take_req        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          state_next      = ST_READY;
          lives_next      = LIVES_LOAD;
          sprite_rst_next = 1'b1;
          phase_next      = '0;
        end
      end
      ST_READY: begin
        cur_dir_next = DIR_UP;
        moving_next  = 1'b0;
        if (bus.tick) begin
          if (phase_reg == READY_LAST) begin
            state_next = ST_PLAY;
            phase_next = '0;
            div_next   = '0;
          end else begin
            phase_next = phase_reg + ONE;
          end
        end
      end
      ST_PLAY: begin
        // A ghost hit suppresses any move pulse from a coincident slot.
        if (bus.ghost_hit) begin
          state_next = ST_DYING;
          phase_next = '0;
        end else if (bus.pellet_eaten == ALL_EATEN) begin
          state_next = ST_WON;
`ifdef PAC_PAUSE_EN
        end else if (pause_rise) begin
          state_next = ST_PAUSED;
`endif
        end else if (bus.tick) begin
          div_next = (div_reg == DIV_LAST) ? '0 : div_reg + ONE;
          if (div_reg == DIV_LAST) begin
            if (req_valid && !wall_vec[req_dir]) begin
              cur_dir_next    = req_dir;
              moving_next     = 1'b1;
              take_req        = 1'b1;
              move_valid_next = 1'b1;
              move_dir_next   = req_dir;
            end else if (moving_reg && !wall_vec[cur_dir_reg]) begin
              move_valid_next = 1'b1;
              move_dir_next   = cur_dir_reg;
            end else begin
              moving_next = 1'b0;
            end
          end
        end
      end
      ST_DYING: begin
        if (bus.tick) begin
          if (phase_reg == DEATH_LAST) begin
            phase_next = '0;
            if (lives_reg <= 2'd1) begin
              state_next = ST_OVER;
              lives_next = 2'd0;
            end else begin
              state_next      = ST_READY;
              lives_next      = lives_reg - 2'd1;
              sprite_rst_next = 1'b1;
            end
          end else begin
            phase_next = phase_reg + ONE;
          end
        end
      end
      ST_WON, ST_OVER: begin
        if (bus.start) state_next = ST_IDLE;
      end
`ifdef PAC_PAUSE_EN
      ST_PAUSED: begin
        if (pause_rise) state_next = ST_PLAY;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      lives_reg      <= 2'd0;
      cur_dir_reg    <= DIR_UP;
      moving_reg     <= 1'b0;
      div_reg        <= '0;
      phase_reg      <= '0;
      move_valid_reg <= 1'b0;
      move_dir_reg   <= DIR_UP;
      sprite_rst_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      lives_reg      <= lives_next;
      cur_dir_reg    <= cur_dir_next;
      moving_reg     <= moving_next;
      div_reg        <= div_next;
      phase_reg      <= phase_next;
      move_valid_reg <= move_valid_next;
      move_dir_reg   <= move_dir_next;
      sprite_rst_reg <= sprite_rst_next;
    end
  end

  assign bus.move_valid = move_valid_reg;
  assign bus.move_dir   = move_dir_reg;
  assign bus.cur_dir    = cur_dir_reg;
  assign bus.state      = state_reg;
  assign bus.lives      = lives_reg;
  assign bus.sprite_rst = sprite_rst_reg;

endmodule

// File: tb/tb_pac_move_sched.sv
// Directed-plus-random bench for pac_move_sched, checked every cycle against a tick-counting game model.
module tb_pac_move_sched;
  import pac_pkg::*;

  localparam int TICK_DIV    = 5;
  localparam int READY_TICKS = 20;
  localparam int DEATH_TICKS = 15;
  localparam int LIVES       = 3;
  localparam int BUF_TICKS   = 8;
  localparam int NP          = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pac_move_sched_if #(.NUM_PELLETS(NP)) bus ();

  pac_move_sched #(
    .TICK_DIV    (TICK_DIV),
    .READY_TICKS (READY_TICKS),
    .DEATH_TICKS (DEATH_TICKS),
    .LIVES       (LIVES),
    .BUF_TICKS   (BUF_TICKS),
    .NUM_PELLETS (NP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Model: time is measured in ticks since entering a state, and a request by its age since the last press.
  int m_state, m_lives, m_cur, m_ticks, m_play_ticks, m_req_dir, m_req_age, e_md;
  bit m_moving, m_req_valid, e_mv, e_sr;
  int obs_pulses;
  bit found;
  logic [3:0] rb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_lives = 0; m_cur = 0; m_moving = 0; m_ticks = 0; m_play_ticks = 0;
    m_req_valid = 0; m_req_dir = 0; m_req_age = 0; e_mv = 0; e_md = 0; e_sr = 0;
  endtask

  task automatic model_update();
    logic [3:0] b, w;
    bit take;
    int win;
    b = {bus.btn_down, bus.btn_left, bus.btn_right, bus.btn_up};
    w = {bus.wall_down, bus.wall_left, bus.wall_right, bus.wall_up};
    e_mv = 0; e_sr = 0; take = 0; win = 0;
    case (m_state)
      0: if (bus.start) begin m_state = 1; m_lives = LIVES; e_sr = 1; m_ticks = 0; end
      1: begin
        m_cur = 0; m_moving = 0;
        if (bus.tick) begin
          m_ticks++;
          if (m_ticks == READY_TICKS) begin m_state = 2; m_play_ticks = 0; end
        end
      end
      2: begin
        if (bus.ghost_hit) begin m_state = 3; m_ticks = 0; end
        else if (bus.pellet_eaten == '1) m_state = 4;
        else if (bus.tick) begin
          m_play_ticks++;
          if (m_play_ticks % TICK_DIV == 0) begin
            if (m_req_valid && !w[m_req_dir]) begin
              m_cur = m_req_dir; m_moving = 1; take = 1; e_mv = 1; e_md = m_req_dir;
            end else if (m_moving && !w[m_cur]) begin
              e_mv = 1; e_md = m_cur;
            end else m_moving = 0;
          end
        end
        for (int i = 3; i >= 0; i--) if (b[i]) win = i;
        if (b != 4'b0) begin m_req_valid = 1; m_req_age = 0; m_req_dir = win; end
        else if (take) m_req_valid = 0;
        else if (bus.tick && m_req_valid) begin
          m_req_age++;
          if (m_req_age >= BUF_TICKS) m_req_valid = 0;
        end
      end
      3: if (bus.tick) begin
        m_ticks++;
        if (m_ticks == DEATH_TICKS) begin
          m_ticks = 0;
          if (m_lives <= 1) begin m_state = 5; m_lives = 0; end
          else begin m_lives--; m_state = 1; e_sr = 1; end
        end
      end
      default: if (bus.start) m_state = 0;
    endcase
    if (m_state != 2) m_req_valid = 0;
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    chk("state", 32'(bus.state), 32'(m_state));
    chk("lives", 32'(bus.lives), 32'(m_lives));
    chk("cur_dir", 32'(bus.cur_dir), 32'(m_cur));
    chk("move_valid", 32'(bus.move_valid), 32'(e_mv));
    chk("sprite_rst", 32'(bus.sprite_rst), 32'(e_sr));
    if (e_mv) chk("move_dir", 32'(bus.move_dir), 32'(e_md));
    if (bus.move_valid === 1'b1) obs_pulses++;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
      repeat ($urandom_range(0, 2)) step();
      $display("tick state=%0d lives=%0d cur_dir=%0d pulses=%0d", bus.state, bus.lives, bus.cur_dir, obs_pulses);
    end
  endtask

  task automatic set_btn(input logic [3:0] v);
    bus.btn_up = v[0]; bus.btn_right = v[1]; bus.btn_left = v[2]; bus.btn_down = v[3];
  endtask

  task automatic set_wall(input logic [3:0] v);
    bus.wall_up = v[0]; bus.wall_right = v[1]; bus.wall_left = v[2]; bus.wall_down = v[3];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tick = 0; bus.start = 0; bus.ghost_hit = 0; bus.pellet_eaten = '0;
    set_btn(4'b0); set_wall(4'b0);
`ifdef PAC_PAUSE_EN
    bus.pause = 0;
`endif
    model_reset();
    obs_pulses = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(bus.state), 32'(ST_IDLE));
    chk("reset_lives", 32'(bus.lives), 0);
    chk("reset_move_valid", 32'(bus.move_valid), 0);
    chk("reset_cur_dir", 32'(bus.cur_dir), 0);
    chk("reset_sprite_rst", 32'(bus.sprite_rst), 0);
    rst = 1'b1;
    step();

    // Game start and READY countdown.
    bus.start = 1; step(); bus.start = 0;
    chk("start_sprite_rst", 32'(bus.sprite_rst), 1);
    chk("start_lives", 32'(bus.lives), LIVES);
    step();
    chk("sprite_rst_one_cycle", 32'(bus.sprite_rst), 0);
    do_ticks(READY_TICKS - 1);
    chk("ready_hold", 32'(bus.state), 32'(ST_READY));
    do_ticks(1);
    chk("play_after_ready", 32'(bus.state), 32'(ST_PLAY));

    // Steady stepping right: one pulse per TICK_DIV ticks.
    bus.btn_right = 1; obs_pulses = 0;
    do_ticks(3 * TICK_DIV);
    bus.btn_right = 0;
    chk("right_pulses", 32'(obs_pulses), 3);
    chk("right_heading", 32'(bus.cur_dir), 32'(DIR_RIGHT));

    // Blocked up request survives 4 ticks, then turns at the next slot.
    bus.wall_up = 1; bus.btn_up = 1; step(); bus.btn_up = 0;
    do_ticks(4); bus.wall_up = 0; do_ticks(1);
    chk("turn_up_buffered", 32'(bus.cur_dir), 32'(DIR_UP));
    bus.btn_right = 1; step(); bus.btn_right = 0;
    do_ticks(TICK_DIV);
    chk("turn_right_again", 32'(bus.cur_dir), 32'(DIR_RIGHT));

    // Same request held back 9 ticks has expired by the slot.
    bus.wall_up = 1; bus.btn_up = 1; step(); bus.btn_up = 0;
    do_ticks(9); bus.wall_up = 0; do_ticks(1);
    chk("turn_up_expired", 32'(bus.cur_dir), 32'(DIR_RIGHT));

    // Up beats down.
    bus.btn_up = 1; bus.btn_down = 1; step(); set_btn(4'b0);
    do_ticks(TICK_DIV);
    chk("prio_up_over_down", 32'(bus.cur_dir), 32'(DIR_UP));

    // Random buttons, walls and partial pellet masks.
    for (int k = 0; k < 40; k++) begin
      rb = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      set_btn(rb);
      set_wall(4'($urandom));
      bus.pellet_eaten = 8'($urandom_range(0, 254));
      do_ticks(1);
    end
    set_btn(4'b0); set_wall(4'b0); bus.pellet_eaten = '0;

    // Ghost hit on a slot tick, with a full pellet mask and buttons: DYING, no pulse.
    bus.btn_right = 1;
    for (int k = 0; k < TICK_DIV && ((m_play_ticks + 1) % TICK_DIV != 0); k++) do_ticks(1);
    set_btn(4'b1001); bus.ghost_hit = 1; bus.pellet_eaten = '1; bus.tick = 1;
    step();
    bus.tick = 0; bus.ghost_hit = 0; bus.pellet_eaten = '0; set_btn(4'b0);
    chk("ghost_over_pellets", 32'(bus.state), 32'(ST_DYING));
    chk("ghost_no_pulse", 32'(bus.move_valid), 0);

    // Three deaths end the game.
    do_ticks(DEATH_TICKS);
    chk("death1_state", 32'(bus.state), 32'(ST_READY));
    chk("death1_lives", 32'(bus.lives), 2);
    do_ticks(READY_TICKS);
    bus.ghost_hit = 1; step(); bus.ghost_hit = 0;
    do_ticks(DEATH_TICKS);
    chk("death2_state", 32'(bus.state), 32'(ST_READY));
    chk("death2_lives", 32'(bus.lives), 1);
    do_ticks(READY_TICKS);
    bus.ghost_hit = 1; step(); bus.ghost_hit = 0;
    do_ticks(DEATH_TICKS);
    chk("death3_state", 32'(bus.state), 32'(ST_OVER));
    chk("death3_lives", 32'(bus.lives), 0);
    do_ticks(3);
    chk("over_no_underflow", 32'(bus.lives), 0);
    bus.start = 1; step(); bus.start = 0;
    chk("over_to_idle", 32'(bus.state), 32'(ST_IDLE));

    // All pellets eaten wins.
    bus.start = 1; step(); bus.start = 0;
    do_ticks(READY_TICKS);
    bus.pellet_eaten = '1; step(); bus.pellet_eaten = '0;
    chk("won_state", 32'(bus.state), 32'(ST_WON));
    bus.start = 1; step(); bus.start = 0;
    chk("won_to_idle", 32'(bus.state), 32'(ST_IDLE));

    // Asynchronous reset while a move pulse is on the output.
    bus.start = 1; step(); bus.start = 0;
    do_ticks(READY_TICKS);
    bus.btn_right = 1; found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      bus.tick = (i % 2 == 0);
      step();
      if (e_mv) found = 1;
    end
    bus.tick = 0;
    chk("reset_search_timeout", 32'(found), 1);
    #1 rst = 1'b0;
    #1;
    chk("async_reset_state", 32'(bus.state), 32'(ST_IDLE));
    chk("async_reset_lives", 32'(bus.lives), 0);
    chk("async_reset_move_valid", 32'(bus.move_valid), 0);
    chk("async_reset_cur_dir", 32'(bus.cur_dir), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.btn_right = 0;
    model_reset();
    step();
    chk("after_reset_idle", 32'(bus.state), 32'(ST_IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pac_move_sched.md
Name: pac_move_sched

Overview:
- Game-level controller that sequences the Pac-Man sprite datapath.
- Owns the game state machine (idle / ready / play / dying / won / over) and the lives counter.
- Arbitrates the four direction buttons into one buffered turn request and issues one-cycle move pulses at a fixed step rate.
- Sits between the button synchronisers and the sprite position/collision block.
- Consumes the sprite block's per-direction wall flags, pellet mask and ghost-hit flag.

Parameters:
- TICK_DIV, 5: frame ticks per movement step slot.
- READY_TICKS, 20: ticks spent in READY before play starts.
- DEATH_TICKS, 15: ticks spent in DYING.
- LIVES, 3: lives loaded on game start; range 1..3.
- BUF_TICKS, 8: ticks a pressed direction stays buffered while blocked.
- NUM_PELLETS, 8: width of the pellet mask.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- tick  in  1  frame-rate strobe, one clk wide.
- start  in  1  start/acknowledge, level, already synchronised.
- btn_up, btn_right, btn_left, btn_down  in  1 each  direction buttons, levels, synchronised.
- wall_up, wall_right, wall_left, wall_down  in  1 each  move in that direction is blocked at the current position.
- pellet_eaten  in  NUM_PELLETS  sticky eaten mask from the sprite block.
- ghost_hit  in  1  Pac-Man overlaps a ghost.
- move_valid  out  1  one-cycle step command.
- move_dir  out  2  step direction: 0 up, 1 right, 2 left, 3 down.
- cur_dir  out  2  current heading.
- state  out  3  game state code.
- lives  out  2  remaining lives.
- sprite_rst  out  1  one-cycle respawn pulse to the sprite block.

Behaviour:
- Reset (rst low, async):
  - state=IDLE(0), lives=0, cur_dir=0, moving=0.
  - move_valid=0, move_dir=0, sprite_rst=0.
  - Request buffer and all counters cleared.
- State codes: IDLE 0, READY 1, PLAY 2, DYING 3, WON 4, OVER 5.
- IDLE: start=1 -> READY. Same edge: lives=LIVES, sprite_rst pulses 1 cycle.
- READY: counts READY_TICKS ticks, then -> PLAY. Divider cleared on PLAY entry. cur_dir=0, moving=0.
- PLAY:
  - ghost_hit -> DYING. ghost_hit has priority over a full pellet mask in the same cycle.
  - Otherwise &pellet_eaten -> WON.
- DYING:
  - After DEATH_TICKS ticks, lives decrements.
  - lives was 1 -> OVER (lives=0).
  - Else -> READY with a sprite_rst pulse.
- WON / OVER: start=1 -> IDLE.
- Arbiter (PLAY only):
  - Priority up > right > left > down; only the winner is taken.
  - A pressed button loads req_dir, sets req_valid and reloads buf_cnt=BUF_TICKS.
  - Each tick decrements buf_cnt; req_valid clears when it reaches 0.
  - A press and a tick in the same cycle: reload wins, no decrement.
  - Buffer cleared on leaving PLAY.
- Step slot: the divider counts ticks 0..TICK_DIV-1; wrap at TICK_DIV-1 opens a slot. At the slot:
  - req_valid and !wall[req_dir]: cur_dir=req_dir, moving=1, req_valid=0, move_valid pulse with move_dir=req_dir.
  - Else moving and !wall[cur_dir]: pulse with move_dir=cur_dir.
  - Else moving=0, no pulse.
- move_valid is asserted the cycle after the slot-opening tick (latency 1 clk). At most one pulse per slot.
- lives never underflows. move_valid is never asserted outside PLAY.
- ghost_hit and the slot in the same cycle: no move pulse, go to DYING.

Optional Feature:
- Macro PAC_PAUSE_EN.
- Defined:
  - Adds input port pause (1 bit).
  - In PLAY, a pause rising edge toggles the paused flag.
  - While paused: state=PAUSED(6); divider, buffer and READY/DYING counters hold; no move_valid; ghost_hit ignored; buttons ignored.
  - Next pause rising edge -> PLAY with counters resumed.
- Undefined: no pause port; code 6 is never produced.

Decomposition:
- Package pac_pkg: state codes, direction codes (DIR_UP..DIR_DOWN), default parameter constants, state/direction typedefs.
- Sub-module pac_dir_arb: priority encoder, request buffer and buf_cnt. Inputs: buttons, tick, clear. Outputs: req_valid, req_dir.
- The top module keeps the FSM, divider, lives and slot logic.

Test Plan:
- Reset mid-PLAY (rst low for 1 cycle) -> state=0, lives=0, move_valid=0 immediately, before the next clk edge.
- start=1 in IDLE -> sprite_rst one pulse, lives=3. After 20 ticks, state=2.
- PLAY, btn_right held, no walls, TICK_DIV=5 -> move_valid every 5th tick, move_dir=1, one clk after that tick.
- btn_up pressed while wall_up=1, wall cleared 4 ticks later -> turn to dir 0 at the next slot. Repeat with the wall cleared after 9 ticks -> request expired, heading unchanged.
- btn_up and btn_down pressed together -> req_dir=0. Same cycle as ghost_hit=1 with pellet_eaten=8'hFF -> state=3, not 4.
- Three deaths from lives=3 -> READY, READY, then OVER with lives=0. start in OVER -> IDLE.
